// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared pipeline types for the memory-access stage: EX/MEM
//                and MEM/WB flow structs, memory control fields, funct3
//                access widths, forwarding record and MEM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int DATA_W = 32;

    // funct3 access-width encodings shared by loads and stores
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    // Normalised access sizes
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        MTR_ALU = 2'd0,
        MTR_MEM = 2'd1,
        MTR_PC  = 2'd2,
        MTR_IMM = 2'd3
    } memtoreg_t;

    typedef struct packed {
        logic      RegWrite;
        memtoreg_t MemtoReg;
    } wb_ctrl_t;

    typedef struct packed {
        logic       MemRead;
        logic       MemWrite;
        logic [2:0] funct3;
    } mem_ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] rs2_data;
        mem_ctrl_t         mem_ctrl;
        wb_ctrl_t          wb_ctrl;
        logic [4:0]        rd_addr;
        logic [DATA_W-1:0] pc_write;
        logic [DATA_W-1:0] immediate;
    } ex_mem_flow_t;

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] data_in;
        wb_ctrl_t          wb_ctrl;
        logic [4:0]        rd_addr;
        logic [DATA_W-1:0] pc_write;
        logic [DATA_W-1:0] immediate;
    } mem_wb_flow_t;

    typedef struct packed {
        logic              RegWrite;
        logic [4:0]        rd_addr;
        logic [DATA_W-1:0] rd_data;
        logic              is_load;
    } fwd_src_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Stores only know SB/SH/SW; loads also accept the unsigned variants.
    // Anything unrecognised is a full word.
    function automatic logic [1:0] access_size(input logic is_store, input logic [2:0] funct3);
        logic [1:0] sz;
        sz = SZ_W;
        if (is_store) begin
            if (funct3 == MEM_B)      sz = SZ_B;
            else if (funct3 == MEM_H) sz = SZ_H;
        end else begin
            if (funct3 == MEM_B || funct3 == MEM_BU)      sz = SZ_B;
            else if (funct3 == MEM_H || funct3 == MEM_HU) sz = SZ_H;
        end
        return sz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/forwarding_if.sv
`default_nettype none
// ============================================================================
//  Module      : forwarding_if
//  Description : Forwarding/hazard bundle; the MEM stage publishes its
//                in-flight destination, the hazard unit consumes it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface forwarding_if;
    import mem_stage_pkg::*;

    fwd_src_t mem;

    modport mem_stage (output mem);
    modport hazard    (input  mem);
endinterface
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_align
//  Description : Combinational lane logic: store byte enables and lane
//                replication, load extraction/extension, misalign detect.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    input  logic            is_store,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic            misalign
);

    logic [1:0]      w_size;
    logic [XLEN-1:0] w_shifted;

    // Store lanes and alignment check from the normalised access size
    always_comb begin
        w_size   = access_size(is_store, funct3);
        be       = 4'b1111;
        wdata    = store_data;
        misalign = 1'b0;
        case (w_size)
            SZ_B: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            SZ_H: begin
                be       = 4'b0011 << addr_lo;
                wdata    = {2{store_data[15:0]}};
                misalign = addr_lo[0];
            end
            default: begin
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

    // Load: bring the addressed lane down to bit 0, then extend
    always_comb begin
        w_shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            MEM_B:   load_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            MEM_BU:  load_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            MEM_H:   load_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            MEM_HU:  load_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            default: load_data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Pipeline MEM stage: data-memory req/ack handshake with
//                timeout, store lanes, load alignment, MEM/WB register,
//                front-end stall and forwarding publication.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int XLEN       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  ex_mem_flow_t      inflow,
    input  logic              in_valid,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ack,
    output logic              mem_stall,
    output logic              misalign,
    output logic              bus_err,
    output mem_wb_flow_t      outflow,
    output logic              out_valid,
    forwarding_if.mem_stage   fd
);

    localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    mem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            we_q, we_d;
    mem_wb_flow_t    outflow_q, outflow_d;
    logic            out_valid_q, out_valid_d;
    logic            misalign_q, misalign_d;
    logic            bus_err_q, bus_err_d;

    logic            w_access;
    logic            w_is_store;
    logic            w_misalign;
    logic            w_issue;
    logic            w_at_limit;
    logic            w_capture;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_load_data;
    fwd_src_t        w_fwd;

    assign w_access   = in_valid & (inflow.mem_ctrl.MemRead | inflow.mem_ctrl.MemWrite);
    assign w_is_store = inflow.mem_ctrl.MemWrite;
    assign w_issue    = (state_q == IDLE) & w_access & ~w_misalign;
    assign w_at_limit = (cnt_q == CNT_W'(WAIT_LIMIT - 1));

    mem_align #(.XLEN(XLEN)) u_align (
        .addr_lo    (inflow.alu_result[1:0]),
        .funct3     (inflow.mem_ctrl.funct3),
        .is_store   (w_is_store),
        .store_data (inflow.rs2_data),
        .rdata      (dmem_rdata),
        .be         (w_be),
        .wdata      (w_wdata),
        .load_data  (w_load_data),
        .misalign   (w_misalign)
    );

    // Bus drive and stall; gated by rst so a reset mid-access drops them at once
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = 4'b0000;
        dmem_wdata = '0;
        mem_stall  = 1'b0;
        if (!rst) begin
            if (state_q == WAIT) begin
                dmem_req   = 1'b1;
                dmem_we    = we_q;
                dmem_addr  = addr_q;
                dmem_be    = be_q;
                dmem_wdata = wdata_q;
                // Timeout cycle releases the stall so the failed op drains
                mem_stall  = ~dmem_ack & ~w_at_limit;
            end else if (w_issue) begin
                dmem_req   = 1'b1;
                dmem_we    = w_is_store;
                dmem_addr  = {inflow.alu_result[XLEN-1:2], 2'b00};
                dmem_be    = w_be;
                dmem_wdata = w_wdata;
                mem_stall  = ~dmem_ack;
            end
        end
    end

    // Next-state, request hold copies and MEM/WB contents
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        outflow_d   = '0;
        out_valid_d = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        w_capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && !w_access) begin
                    w_capture = 1'b1;
                end else if (w_access && w_misalign) begin
                    misalign_d = 1'b1;
                end else if (w_issue) begin
                    if (dmem_ack) begin
                        w_capture = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = '0;
                        addr_d  = {inflow.alu_result[XLEN-1:2], 2'b00};
                        be_d    = w_be;
                        wdata_d = w_wdata;
                        we_d    = w_is_store;
                    end
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    w_capture = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else if (w_at_limit) begin
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (w_capture) begin
            out_valid_d          = 1'b1;
            outflow_d.alu_result = inflow.alu_result;
            outflow_d.wb_ctrl    = inflow.wb_ctrl;
            outflow_d.rd_addr    = inflow.rd_addr;
            outflow_d.pc_write   = inflow.pc_write;
            outflow_d.immediate  = inflow.immediate;
            outflow_d.data_in    = (w_access && inflow.mem_ctrl.MemRead && !w_is_store)
                                   ? w_load_data : '0;
        end
    end

    // State and MEM/WB register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            be_q        <= 4'b0000;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            outflow_q   <= '0;
            out_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            outflow_q   <= outflow_d;
            out_valid_q <= out_valid_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Forwarding record for the instruction currently in MEM
    always_comb begin
        w_fwd.RegWrite = in_valid & inflow.wb_ctrl.RegWrite;
        w_fwd.rd_addr  = inflow.rd_addr;
        w_fwd.is_load  = in_valid & inflow.mem_ctrl.MemRead;
        case (inflow.wb_ctrl.MemtoReg)
            MTR_PC:  w_fwd.rd_data = inflow.pc_write;
            MTR_IMM: w_fwd.rd_data = inflow.immediate;
            default: w_fwd.rd_data = inflow.alu_result;
        endcase
    end

    assign fd.mem    = w_fwd;
    assign outflow   = outflow_q;
    assign out_valid = out_valid_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage with a behavioural
//                reference model and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int WAIT_LIMIT = 16;

    logic         clk = 1'b0;
    logic         rst;
    ex_mem_flow_t inflow;
    logic         in_valid;
    logic         dmem_req, dmem_we, dmem_ack;
    logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]   dmem_be;
    logic         mem_stall, misalign, bus_err, out_valid;
    mem_wb_flow_t outflow;

    forwarding_if fwd ();

    mem_stage #(.WAIT_LIMIT(WAIT_LIMIT), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .inflow     (inflow),
        .in_valid   (in_valid),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .mem_stall  (mem_stall),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .outflow    (outflow),
        .out_valid  (out_valid),
        .fd         (fwd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_size(input logic st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    endfunction

    function automatic logic [3:0] ref_be(input int sz, input logic [31:0] addr);
        int off;
        off = int'(addr % 4);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] ref_wdata(input int sz, input logic [31:0] d);
        if (sz == 1) return (d % 256) * 32'h0101_0101;
        if (sz == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int unsigned v;
        int          s;
        v = rd >> (8 * (addr % 4));
        case (f3)
            3'd0: begin s = int'(v % 256);   if (s >= 128)   s -= 256;   return 32'(s); end
            3'd4: return v % 256;
            3'd1: begin s = int'(v % 65536); if (s >= 32768) s -= 65536; return 32'(s); end
            3'd5: return v % 65536;
            default: return rd;
        endcase
    endfunction

    function automatic ex_mem_flow_t make_flow(input logic rd_en, input logic wr_en,
                                               input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rs2);
        ex_mem_flow_t f;
        f.alu_result        = addr;
        f.rs2_data          = rs2;
        f.mem_ctrl.MemRead  = rd_en;
        f.mem_ctrl.MemWrite = wr_en;
        f.mem_ctrl.funct3   = f3;
        f.wb_ctrl.RegWrite  = 1'($urandom);
        f.wb_ctrl.MemtoReg  = memtoreg_t'(2'($urandom));
        f.rd_addr           = 5'($urandom);
        f.pc_write          = $urandom;
        f.immediate         = $urandom;
        return f;
    endfunction

    // Present one instruction; memory acks `lat` cycles after the issue cycle
    task automatic run_instr(input ex_mem_flow_t f, input logic v, input int lat,
                             input logic [31:0] rd);
        logic        acc, st, mis, done, exp_valid;
        int          sz, last;
        logic [31:0] exp_fwd;
        acc  = v && (f.mem_ctrl.MemRead || f.mem_ctrl.MemWrite);
        st   = f.mem_ctrl.MemWrite;
        sz   = ref_size(st, f.mem_ctrl.funct3);
        mis  = acc && ((f.alu_result % sz) != 0);
        done = acc && !mis && (lat <= WAIT_LIMIT);
        last = (!acc || mis) ? 0 : ((lat < WAIT_LIMIT) ? lat : WAIT_LIMIT);
        case (f.wb_ctrl.MemtoReg)
            MTR_PC:  exp_fwd = f.pc_write;
            MTR_IMM: exp_fwd = f.immediate;
            default: exp_fwd = f.alu_result;
        endcase
        inflow   = f;
        in_valid = v;
        for (int c = 0; c <= last; c++) begin
            dmem_ack   = acc && !mis && (c == lat);
            dmem_rdata = dmem_ack ? rd : $urandom;
            @(negedge clk);
            check("req", dmem_req, acc && !mis);
            check("stall", mem_stall, c < last);
            if (acc && !mis) begin
                check("addr", dmem_addr, f.alu_result & 32'hFFFF_FFFC);
                check("we", dmem_we, st);
                if (st) begin
                    check("be", dmem_be, ref_be(sz, f.alu_result));
                    check("wdata", dmem_wdata, ref_wdata(sz, f.rs2_data));
                end
            end
            if (c == 0) begin
                check("fwd_regwrite", fwd.mem.RegWrite, v && f.wb_ctrl.RegWrite);
                check("fwd_rd", fwd.mem.rd_addr, f.rd_addr);
                check("fwd_data", fwd.mem.rd_data, exp_fwd);
                check("fwd_load", fwd.mem.is_load, v && f.mem_ctrl.MemRead);
            end
            @(posedge clk);
            #1;
            if (c < last) check("bubble_valid", out_valid, 1'b0);
        end
        dmem_ack  = 1'b0;
        exp_valid = v && (!acc || done);
        check("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            check("out_alu", outflow.alu_result, f.alu_result);
            check("out_rd", outflow.rd_addr, f.rd_addr);
            check("out_regwrite", outflow.wb_ctrl.RegWrite, f.wb_ctrl.RegWrite);
            check("out_pc", outflow.pc_write, f.pc_write);
            check("out_data", outflow.data_in,
                  (acc && f.mem_ctrl.MemRead && !st) ? ref_load(f.mem_ctrl.funct3, f.alu_result, rd) : 32'd0);
        end else begin
            check("bubble_regwrite", outflow.wb_ctrl.RegWrite, 1'b0);
        end
        check("misalign", misalign, mis);
        check("bus_err", bus_err, acc && !mis && !done);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ex_mem_flow_t f;
        int           kind, r, lat;
        logic [2:0]   f3;
        logic [2:0]   f3_tab [5];
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        rst        = 1'b1;
        inflow     = '0;
        in_valid   = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_outflow_alu", outflow.alu_result, 32'd0);
        check("rst_outflow_rw", outflow.wb_ctrl.RegWrite, 1'b0);
        check("rst_req", dmem_req, 1'b0);
        check("rst_we", dmem_we, 1'b0);
        check("rst_stall", mem_stall, 1'b0);
        check("rst_misalign", misalign, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        rst = 1'b0;

        // ADD: plain capture, no request
        f = make_flow(1'b0, 1'b0, 3'd0, 32'h1234, 32'h0);
        f.wb_ctrl.RegWrite = 1'b1;
        f.wb_ctrl.MemtoReg = MTR_ALU;
        run_instr(f, 1'b1, 0, 32'h0);
        // LB / LBU on top byte, ack in the issue cycle
        run_instr(make_flow(1'b1, 1'b0, MEM_B,  32'h103, 32'h0), 1'b1, 0, 32'h80FF_0000);
        run_instr(make_flow(1'b1, 1'b0, MEM_BU, 32'h103, 32'h0), 1'b1, 0, 32'h80FF_0000);
        // SH upper half with three wait cycles
        run_instr(make_flow(1'b0, 1'b1, MEM_H, 32'h202, 32'hABCD_1234), 1'b1, 3, 32'h0);
        // Misaligned word load
        run_instr(make_flow(1'b1, 1'b0, MEM_W, 32'h101, 32'h0), 1'b1, 0, 32'h0);
        // Timeout, then ack landing on the final permitted cycle
        run_instr(make_flow(1'b1, 1'b0, MEM_W, 32'h300, 32'h0), 1'b1, WAIT_LIMIT + 1, 32'h0);
        run_instr(make_flow(1'b1, 1'b0, MEM_W, 32'h304, 32'h0), 1'b1, WAIT_LIMIT, 32'h5566_7788);

        // Reset in the middle of a wait
        inflow   = make_flow(1'b1, 1'b0, MEM_W, 32'h400, 32'h0);
        in_valid = 1'b1;
        dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_req", dmem_req, 1'b0);
        check("midrst_stall", mem_stall, 1'b0);
        check("midrst_valid", out_valid, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_instr(make_flow(1'b0, 1'b1, MEM_W, 32'h500, 32'hCAFE_F00D), 1'b1, 1, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            f3   = ($urandom_range(0, 3) != 0) ? f3_tab[$urandom_range(0, 4)] : 3'($urandom);
            r    = $urandom_range(0, 19);
            lat  = (r < 16) ? (r % 5) : (WAIT_LIMIT - 2 + (r - 16));
            if (kind < 2)
                f = make_flow(1'b0, 1'b0, f3, $urandom, $urandom);
            else if (kind < 6)
                f = make_flow(1'b1, 1'b0, f3, $urandom, $urandom);
            else
                f = make_flow(1'b0, 1'b1, f3, $urandom, $urandom);
            run_instr(f, kind != 9, lat, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
